// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: prefix stall mask, multi-cycle flush sequencer
// with redirect PC, stall watchdog and saturating stall/flush counters.
module pipe_ctrl #(
   parameter int NSTAGE     = 6,
   parameter int PC_W       = 32,
   parameter int FLUSH_LEN  = 1,
   parameter int CNT_W      = 32,
   parameter int WDOG_LIMIT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stallreq,
   input  logic              flush_req,
   input  logic [PC_W-1:0]   flush_pc,
   input  logic              cnt_clr,
   output logic [NSTAGE-1:0] stall,
   output logic              flush,
   output logic [PC_W-1:0]   new_pc,
   output logic              busy,
   output logic              stall_timeout,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_count
);

   localparam int  REM_W   = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN + 1) : 1;
   localparam int  RUN_W   = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT + 1) : 1;
   localparam bit  WDOG_EN = (WDOG_LIMIT > 0);
   localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(WDOG_LIMIT);

   typedef enum logic {S_IDLE, S_FLUSH} state_t;

   state_t            state_q, state_d;
   logic [REM_W-1:0]  rem_q, rem_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  stall_cyc_q, stall_cyc_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic              tmo_q, tmo_d;
   logic [NSTAGE-1:0] mask;
   logic              accept;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Highest requesting stage holds itself and everything upstream of it.
   always_comb begin
      logic acc;
      acc  = 1'b0;
      mask = '0;
      for (int j = NSTAGE - 1; j >= 0; j--) begin
         acc     = acc | stallreq[j];
         mask[j] = acc;
      end
   end

   assign accept = (state_q == S_IDLE) && flush_req;

   always_comb begin
      if (rst || (state_q == S_FLUSH) || accept)
         stall = '0;
      else
         stall = mask;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         pc_q    <= pc_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      pc_d    = pc_q;
      case (state_q)
         S_IDLE: begin
            if (flush_req) begin
               state_d = S_FLUSH;
               rem_d   = REM_W'(FLUSH_LEN);
               pc_d    = flush_pc;
            end
         end
         S_FLUSH: begin
            rem_d = rem_q - REM_W'(1);
            if (rem_q <= REM_W'(1))
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      flush  = (state_q == S_FLUSH);
      busy   = (state_q == S_FLUSH);
      new_pc = pc_q;
   end

   // Counters and watchdog; clear takes priority over any increment or set.
   always_comb begin
      stall_cyc_d = stall_cyc_q;
      flush_cnt_d = flush_cnt_q;
      run_d       = run_q;
      tmo_d       = tmo_q;
      if (cnt_clr) begin
         stall_cyc_d = '0;
         flush_cnt_d = '0;
         run_d       = '0;
         tmo_d       = 1'b0;
      end else begin
         if (stall[0])
            stall_cyc_d = sat_inc(stall_cyc_q);
         if (accept)
            flush_cnt_d = sat_inc(flush_cnt_q);
         if (!WDOG_EN || !stall[0])
            run_d = '0;
         else if (run_q != RUN_LIM)
            run_d = run_q + RUN_W'(1);
         if (WDOG_EN && stall[0] && (run_d == RUN_LIM))
            tmo_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cyc_q <= '0;
         flush_cnt_q <= '0;
         run_q       <= '0;
         tmo_q       <= 1'b0;
      end else begin
         stall_cyc_q <= stall_cyc_d;
         flush_cnt_q <= flush_cnt_d;
         run_q       <= run_d;
         tmo_q       <= tmo_d;
      end
   end

   assign stall_cycles  = stall_cyc_q;
   assign flush_count   = flush_cnt_q;
   assign stall_timeout = tmo_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a 6-stage build (FLUSH_LEN=3, WDOG_LIMIT=4) and an
// 8-stage build (FLUSH_LEN=1, CNT_W=3, watchdog disabled) share clock and reset.
module tb_pipe_ctrl;

   logic clk;
   logic rst;

   logic [5:0]  a_stallreq;
   logic        a_flush_req;
   logic [31:0] a_flush_pc;
   logic        a_cnt_clr;
   logic [5:0]  a_stall;
   logic        a_flush;
   logic [31:0] a_new_pc;
   logic        a_busy;
   logic        a_timeout;
   logic [31:0] a_stall_cycles;
   logic [31:0] a_flush_count;

   logic [7:0]  b_stallreq;
   logic        b_flush_req;
   logic [15:0] b_flush_pc;
   logic        b_cnt_clr;
   logic [7:0]  b_stall;
   logic        b_flush;
   logic [15:0] b_new_pc;
   logic        b_busy;
   logic        b_timeout;
   logic [2:0]  b_stall_cycles;
   logic [2:0]  b_flush_count;

   int tests = 0;
   int fails = 0;

   pipe_ctrl #(.NSTAGE(6), .PC_W(32), .FLUSH_LEN(3), .CNT_W(32), .WDOG_LIMIT(4)) u_a (
      .clk(clk), .rst(rst), .stallreq(a_stallreq), .flush_req(a_flush_req),
      .flush_pc(a_flush_pc), .cnt_clr(a_cnt_clr), .stall(a_stall), .flush(a_flush),
      .new_pc(a_new_pc), .busy(a_busy), .stall_timeout(a_timeout),
      .stall_cycles(a_stall_cycles), .flush_count(a_flush_count)
   );

   pipe_ctrl #(.NSTAGE(8), .PC_W(16), .FLUSH_LEN(1), .CNT_W(3), .WDOG_LIMIT(0)) u_b (
      .clk(clk), .rst(rst), .stallreq(b_stallreq), .flush_req(b_flush_req),
      .flush_pc(b_flush_pc), .cnt_clr(b_cnt_clr), .stall(b_stall), .flush(b_flush),
      .new_pc(b_new_pc), .busy(b_busy), .stall_timeout(b_timeout),
      .stall_cycles(b_stall_cycles), .flush_count(b_flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_stallreq = 6'b001000; a_flush_req = 1'b0; a_flush_pc = '0; a_cnt_clr = 1'b0;
      b_stallreq = 8'hFF;     b_flush_req = 1'b0; b_flush_pc = '0; b_cnt_clr = 1'b0;
      tick(); tick();

      // reset state, with stall requests present
      chk("rst_a_stall", a_stall, 6'b000000);
      chk("rst_b_stall", b_stall, 8'h00);
      chk("rst_flush", a_flush, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_new_pc", a_new_pc, 0);
      chk("rst_timeout", a_timeout, 0);
      chk("rst_stall_cycles", a_stall_cycles, 0);
      chk("rst_flush_count", a_flush_count, 0);

      // combinational prefix mask, all inside one cycle
      rst = 1'b0; b_stallreq = 8'h00;
      a_stallreq = 6'b001000; #1 chk("mask_ex", a_stall, 6'b001111);
      a_stallreq = 6'b001100; #1 chk("mask_ex_id", a_stall, 6'b001111);
      a_stallreq = 6'b000100; #1 chk("mask_id", a_stall, 6'b000111);
      a_stallreq = 6'b000000; #1 chk("mask_none", a_stall, 6'b000000);
      tick();

      // flush accepted while EX stalls
      a_stallreq = 6'b001000; a_flush_req = 1'b1; a_flush_pc = 32'hBFC00380;
      #1 chk("flush_req_stall", a_stall, 6'b000000);
      chk("flush_req_noflush", a_flush, 0);
      tick();
      a_flush_req = 1'b0;
      chk("fl_c1_flush", a_flush, 1);
      chk("fl_c1_busy", a_busy, 1);
      chk("fl_c1_pc", a_new_pc, 32'hBFC00380);
      chk("fl_c1_count", a_flush_count, 1);
      chk("fl_c1_stall", a_stall, 6'b000000);
      tick();
      a_flush_req = 1'b1; a_flush_pc = 32'h12345678;
      chk("fl_c2_flush", a_flush, 1);
      tick();
      a_flush_req = 1'b0;
      chk("fl_c3_flush", a_flush, 1);
      chk("fl_c3_pc", a_new_pc, 32'hBFC00380);
      chk("fl_c3_count", a_flush_count, 1);
      tick();
      chk("fl_end_flush", a_flush, 0);
      chk("fl_end_busy", a_busy, 0);
      chk("fl_end_count", a_flush_count, 1);
      chk("fl_end_stall_cycles", a_stall_cycles, 0);
      chk("fl_end_stall", a_stall, 6'b001111);

      // back-to-back flush in the first IDLE cycle
      a_flush_req = 1'b1; a_flush_pc = 32'h80000000;
      #1 chk("b2b_stall", a_stall, 6'b000000);
      tick();
      a_flush_req = 1'b0; a_stallreq = 6'b000000;
      chk("b2b_flush", a_flush, 1);
      chk("b2b_pc", a_new_pc, 32'h80000000);
      chk("b2b_count", a_flush_count, 2);

      // reset during FLUSH cycle 1
      rst = 1'b1; a_stallreq = 6'b001000;
      #1 chk("rst_mid_stall", a_stall, 6'b000000);
      tick();
      rst = 1'b0; a_stallreq = 6'b000000;
      chk("rstf_flush", a_flush, 0);
      chk("rstf_busy", a_busy, 0);
      chk("rstf_pc", a_new_pc, 0);
      chk("rstf_count", a_flush_count, 0);
      chk("rstf_stall_cycles", a_stall_cycles, 0);
      tick();
      chk("rstf_abandoned", a_flush, 0);

      // watchdog: 3 stalled, 1 free, 4 stalled
      a_stallreq = 6'b000010;
      #1 chk("wd_mask", a_stall, 6'b000011);
      tick(); tick(); tick();
      chk("wd_run3_cycles", a_stall_cycles, 3);
      chk("wd_run3_tmo", a_timeout, 0);
      a_stallreq = 6'b000000;
      tick();
      chk("wd_gap_tmo", a_timeout, 0);
      a_stallreq = 6'b000010;
      tick(); tick(); tick();
      chk("wd_3of4_tmo", a_timeout, 0);
      chk("wd_3of4_cycles", a_stall_cycles, 6);
      tick();
      chk("wd_trip_tmo", a_timeout, 1);
      chk("wd_trip_cycles", a_stall_cycles, 7);
      a_stallreq = 6'b000000;
      tick();
      chk("wd_sticky", a_timeout, 1);
      a_cnt_clr = 1'b1;
      tick();
      a_cnt_clr = 1'b0;
      chk("clr_tmo", a_timeout, 0);
      chk("clr_cycles", a_stall_cycles, 0);
      chk("clr_count", a_flush_count, 0);

      // 8-stage build: mask, counter saturation, disabled watchdog
      b_stallreq = 8'b01000000;
      #1 chk("b_mask_bit6", b_stall, 8'b01111111);
      for (int i = 0; i < 7; i++) tick();
      chk("b_sat_7", b_stall_cycles, 7);
      tick(); tick(); tick();
      chk("b_sat_10", b_stall_cycles, 7);
      chk("b_wdog_off", b_timeout, 0);
      b_cnt_clr = 1'b1;
      tick();
      b_cnt_clr = 1'b0;
      chk("b_clr_wins", b_stall_cycles, 0);
      tick();
      b_stallreq = 8'h00;
      chk("b_after_clr", b_stall_cycles, 1);

      // continuous flush_req with FLUSH_LEN=1: accepted every other edge
      b_flush_req = 1'b1; b_flush_pc = 16'hA5A5;
      tick();
      chk("b_fl1_flush", b_flush, 1);
      chk("b_fl1_pc", b_new_pc, 16'hA5A5);
      chk("b_fl1_count", b_flush_count, 1);
      tick();
      chk("b_fl2_flush", b_flush, 0);
      chk("b_fl2_count", b_flush_count, 1);
      tick();
      chk("b_fl3_count", b_flush_count, 2);
      for (int i = 0; i < 17; i++) tick();
      b_flush_req = 1'b0;
      chk("b_fl_sat", b_flush_count, 7);
      chk("b_fl_idle", b_flush, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline hold/flush controller for the 5-stage CPU core, superseding the fixed six-bit stall generator. It merges per-stage stall requests into a prefix stall mask of configurable depth. It sequences multi-cycle pipeline flushes with a redirect PC, watches for stalls that never resolve, and keeps saturating stall and flush performance counters. The block sits beside the datapath; its `stall` bus drives every pipeline register and its `flush`/`new_pc` drive the PC unit and the inter-stage registers.

## Interface
- `NSTAGE`, 6: number of stall bits; bit 0 = PC, then IF, ID, EX, MEM, WB.
- `PC_W`, 32: width of redirect PC.
- `FLUSH_LEN`, 1: cycles `flush` stays asserted per accepted flush (≥1).
- `CNT_W`, 32: width of performance counters.
- `WDOG_LIMIT`, 1024: consecutive stall cycles that trip the watchdog; 0 disables it.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `stallreq`  in  NSTAGE: bit i = stage i requests a hold.
- `flush_req`  in  1: exception/redirect request, one cycle.
- `flush_pc`  in  PC_W: redirect target, valid with `flush_req`.
- `cnt_clr`  in  1: synchronous clear of counters and the timeout flag.
- `stall`  out  NSTAGE: hold mask, 1 = stage holds.
- `flush`  out  1: clear pipeline registers, redirect PC.
- `new_pc`  out  PC_W: redirect PC, valid while `flush`=1.
- `busy`  out  1: high while in FLUSH state.
- `stall_timeout`  out  1: sticky watchdog flag.
- `stall_cycles`  out  CNT_W: count of cycles with `stall[0]`=1.
- `flush_count`  out  CNT_W: count of accepted flushes.

## Operation
- Stall mask (combinational): k = highest index with `stallreq[k]`=1; `stall[j]`=1 for all j≤k, else 0. No request → all zero. Example with NSTAGE=6: EX request (bit 3) → 001111; ID request (bit 2) → 000111; both → 001111.
- Overrides on `stall`, highest first: `rst`=1 → 0; state FLUSH → 0; `flush_req`=1 in IDLE → 0.
- FSM states:
  - IDLE: when `flush_req`=1, capture `flush_pc` into `new_pc`, load the remaining-cycle counter with FLUSH_LEN, and go to FLUSH.
  - FLUSH: `flush`=1, `busy`=1. Decrement the counter each cycle and return to IDLE after FLUSH_LEN cycles.
- `flush_req` during FLUSH is ignored: not captured, not counted.
- `stall_cycles`: +1 each cycle `stall[0]`=1, saturating at all-ones.
- `flush_count`: +1 per IDLE→FLUSH transition, saturating at all-ones.
- Watchdog run counter:
  - +1 each cycle `stall[0]`=1.
  - Cleared in any cycle with `stall[0]`=0.
  - Saturates at WDOG_LIMIT.
  - When it reaches WDOG_LIMIT, `stall_timeout` sets and stays set.
- `cnt_clr`: zeroes `stall_cycles`, `flush_count`, the run counter and `stall_timeout`. Clear wins over a simultaneous increment or set. It does not affect the FSM.

## Timing
- Reset values: `stall`=0, `flush`=0, `busy`=0, `new_pc`=0, `stall_timeout`=0, both counters 0, FSM=IDLE, run counter 0.
- `stall` has zero latency from `stallreq` in IDLE, with no register in the path.
- `flush_req` sampled high at edge t: `flush`, `busy` and `new_pc`=`flush_pc` are valid in cycles t+1 … t+FLUSH_LEN. `flush` is low in cycle t+FLUSH_LEN+1 unless a new request was sampled at the last FLUSH edge (ignored, so it stays low).
- Back-to-back: a `flush_req` in the first IDLE cycle after FLUSH is accepted normally.
- `flush_count` increments at edge t; `stall_cycles` increments at the edge ending each stalled cycle.
- Watchdog: `stall_timeout` is visible in the cycle after the WDOG_LIMIT-th consecutive stalled cycle.
- `rst` mid-FLUSH: at the next edge all state returns to reset values, and the flush is abandoned.

## Test plan
- Reset, then `stallreq`=001000 → `stall`=001111 same cycle; add bit 2 → still 001111; only bit 2 → 000111; none → 000000.
- FLUSH_LEN=3, `flush_req` with `flush_pc`=0xBFC00380 while `stallreq`=001000:
  - `stall`=0 that cycle.
  - `flush`=`busy`=1 and `new_pc`=0xBFC00380 for exactly 3 cycles.
  - `flush_count`=1.
  - A second `flush_req` in FLUSH cycle 2 is ignored and `flush_count` stays 1.
- WDOG_LIMIT=4:
  - Hold `stallreq[1]` for 3 cycles, drop 1 cycle, then hold 4 → `stall_timeout` rises after the 4th consecutive cycle.
  - `stall_cycles`=7.
  - `cnt_clr` → all cleared next cycle.
- CNT_W=3, stall held 10 cycles → `stall_cycles` saturates at 7; `cnt_clr` coincident with a stall cycle → 0.
- `rst` asserted in FLUSH cycle 1 of FLUSH_LEN=3 → next cycle `flush`=0, `new_pc`=0, `busy`=0, counters 0.
- NSTAGE=8 build: `stallreq` bit 6 → `stall`=01111111.
